// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-memory responder with RAM, output FIFO and MMIO.
// Address map: RAM below 0xFF00 (aliased), 0xFFF0 FIFO data, 0xFFF1 FIFO status,
// 0xFFF2 cycle counter, 0xFFF3 external input; other 0xFFxx read 0.
// Optional feature: define DMEM_CYCLE_COUNTER_EN to build the 16-bit cycle counter.
module data_mem_responder #(
  parameter int unsigned RAM_AW  = 8,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic        CK,
  input  logic        RST,
  input  logic [15:0] DA,
  inout  wire  [15:0] DD,
  input  logic        RW,
  output logic [15:0] OUT_D,
  output logic        OUT_V,
  input  logic        OUT_R,
  input  logic [15:0] IN_D
);

  localparam int unsigned       DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  logic [15:0]        ram_q  [2 ** RAM_AW];
  logic [15:0]        fifo_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               prev_rw_q;
  logic [15:0]        prev_da_q, prev_dd_q;

  logic        in_ram, write_ev, ram_we, push, pop, push_ok, clr_ovf;
  logic        full, empty;
  logic [15:0] head, status, cyc_rd, rdata;

  assign in_ram  = DA < 16'hFF00;
  assign full    = count_q == FULL_CNT;
  assign empty   = count_q == '0;
  // A store only counts as a new event when something changed since last cycle,
  // so a CPU holding a write for several cycles triggers MMIO side effects once.
  assign write_ev = !RW && (prev_rw_q || (DA != prev_da_q) || (DD != prev_dd_q));
  assign ram_we   = !RW && in_ram;
  assign push     = write_ev && (DA == 16'hFFF0);
  assign clr_ovf  = write_ev && (DA == 16'hFFF1);
  assign pop      = !empty && OUT_R;
  assign push_ok  = push && (!full || pop);

  assign head   = empty ? '0 : fifo_q[rd_ptr_q];
  assign OUT_D  = head;
  assign OUT_V  = !empty;
  assign status = {8'h00, 4'(count_q), 1'b0, ovf_q, empty, full};

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [15:0] cyc_q;

  // Free-running cycle counter, wraps naturally at 16 bits
  always_ff @(posedge CK) begin
    if (RST) cyc_q <= '0;
    else     cyc_q <= cyc_q + 16'd1;
  end

  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = '0;
`endif

  // Combinational read mux for the CPU data bus
  always_comb begin
    rdata = '0;
    if (in_ram) begin
      rdata = ram_q[DA[RAM_AW-1:0]];
    end else begin
      case (DA)
        16'hFFF0: rdata = head;
        16'hFFF1: rdata = status;
        16'hFFF2: rdata = cyc_rd;
        16'hFFF3: rdata = IN_D;
        default:  rdata = '0;
      endcase
    end
  end

  assign DD = RW ? rdata : 'z;

  // FIFO pointer, occupancy and overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clr_ovf)                 ovf_d = 1'b0;
    else if (push && !push_ok)   ovf_d = 1'b1;
  end

  // Control state registers, cleared by reset
  always_ff @(posedge CK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      prev_rw_q <= 1'b1;
      prev_da_q <= '0;
      prev_dd_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      prev_rw_q <= RW;
      prev_da_q <= DA;
      prev_dd_q <= DD;
    end
  end

  // RAM storage; contents survive reset
  always_ff @(posedge CK) begin
    if (!RST && ram_we) ram_q[DA[RAM_AW-1:0]] <= DD;
  end

  // FIFO storage; validity is tracked by the pointers, not the data
  always_ff @(posedge CK) begin
    if (!RST && push_ok) fifo_q[wr_ptr_q] <= DD;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: queue-based reference model plus directed literals.
module tb_data_mem_responder;

  logic        CK = 1'b0;
  logic        RST, RW, OUT_R, OUT_V;
  logic [15:0] DA, tb_dd, IN_D, OUT_D;
  wire  [15:0] DD;

  assign DD = RW ? 16'hzzzz : tb_dd;

  always #5 CK = ~CK;

  data_mem_responder #(.RAM_AW(8), .FIFO_AW(3)) dut (
    .CK(CK), .RST(RST), .DA(DA), .DD(DD), .RW(RW),
    .OUT_D(OUT_D), .OUT_V(OUT_V), .OUT_R(OUT_R), .IN_D(IN_D)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] mram [int];
  logic [15:0] q [$];
  logic        movf;
  logic [15:0] mcnt;
  logic        mprv_rw;
  logic [15:0] mprv_da, mprv_dd;
  bit          started = 0;

  function automatic logic [15:0] mread(input logic [15:0] a, output bit known);
    known = 1;
    if (a < 16'hFF00) begin
      if (mram.exists(int'(a[7:0]))) return mram[int'(a[7:0])];
      known = 0;
      return 16'h0;
    end
    case (a)
      16'hFFF0: return (q.size() != 0) ? q[0] : 16'h0;
      16'hFFF1: return {8'h00, 4'(q.size()), 1'b0, movf, q.size() == 0, q.size() == 8};
`ifdef DMEM_CYCLE_COUNTER_EN
      16'hFFF2: return mcnt;
`endif
      16'hFFF3: return IN_D;
      default:  return 16'h0;
    endcase
  endfunction

  always @(posedge CK) begin
    if (RST) begin
      started = 1;
      q.delete();
      movf    = 0;
      mcnt    = 0;
      mprv_rw = 1;
      mprv_da = 0;
      mprv_dd = 0;
    end else begin
      bit ev, pop, was_full;
      ev       = !RW && (mprv_rw || DA != mprv_da || tb_dd != mprv_dd);
      pop      = (q.size() != 0) && OUT_R;
      was_full = q.size() == 8;
      if (!RW && DA < 16'hFF00) mram[int'(DA[7:0])] = tb_dd;
      if (pop) void'(q.pop_front());
      if (ev && DA == 16'hFFF0) begin
        if (!was_full || pop) q.push_back(tb_dd);
        else movf = 1;
      end
      if (ev && DA == 16'hFFF1) movf = 0;
      mcnt    = mcnt + 16'd1;
      mprv_rw = RW;
      mprv_da = DA;
      mprv_dd = tb_dd;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge CK) begin
    if (started) begin
      logic [15:0] e;
      bit k;
      check("out_v", 16'(OUT_V), 16'(q.size() != 0));
      check("out_d", OUT_D, (q.size() != 0) ? q[0] : 16'h0);
      if (RW) begin
        e = mread(DA, k);
        if (k) check("dd_read", DD, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic rw, input logic [15:0] a, input logic [15:0] d, input logic r);
    RW = rw; DA = a; tb_dd = d; OUT_R = r;
    @(posedge CK); #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
    RW = 1; DA = a; OUT_R = 0;
    #2;
    check(name, DD, exp);
    @(posedge CK); #1;
  endtask

  initial begin
    int n;
    logic [15:0] last;
    RST = 1; RW = 1; DA = 16'hFF80; tb_dd = 0; OUT_R = 0; IN_D = 16'hBEEF;
    repeat (2) @(posedge CK);
    #1;
    check("reset_out_v", 16'(OUT_V), 16'h0);
    check("reset_out_d", OUT_D, 16'h0);
    rd(16'hFFF1, 16'h0002, "status_reset");
    RST = 0;
    repeat (10) step(1, 16'hFF80, 0, 0);
`ifdef DMEM_CYCLE_COUNTER_EN
    rd(16'hFFF2, 16'h000A, "cycle_cnt_10");
    repeat (65535) step(1, 16'hFF80, 0, 0);
    rd(16'hFFF2, 16'h000A, "cycle_cnt_wrap");
`else
    rd(16'hFFF2, 16'h0000, "cycle_cnt_absent");
`endif
    rd(16'hFFF3, 16'hBEEF, "in_d_read");
    rd(16'hFF80, 16'h0000, "unmapped_read");

    // RAM aliasing
    step(0, 16'h0010, 16'h1234, 0);
    rd(16'h0110, 16'h1234, "ram_alias");

    // three pushes then drain in order
    step(0, 16'hFFF0, 16'h000A, 0);
    step(0, 16'hFFF0, 16'h000B, 0);
    step(0, 16'hFFF0, 16'h000C, 0);
    rd(16'hFFF1, 16'h0030, "status_3");
    RW = 1; DA = 16'hFF80; OUT_R = 1; #1;
    check("pop_seq0", OUT_D, 16'h000A);
    @(posedge CK); #1;
    check("pop_seq1", OUT_D, 16'h000B);
    @(posedge CK); #1;
    check("pop_seq2", OUT_D, 16'h000C);
    @(posedge CK); #1;
    check("pop_empty_v", 16'(OUT_V), 16'h0);
    OUT_R = 0;

    // overflow and clear
    for (int i = 0; i < 9; i++) step(0, 16'hFFF0, 16'(16'h0100 + i), 0);
    rd(16'hFFF1, 16'h0085, "status_ovf");
    step(0, 16'hFFF1, 16'h0000, 0);
    rd(16'hFFF1, 16'h0081, "status_clr");

    // push + pop while full
    step(0, 16'hFFF0, 16'h0055, 1);
    rd(16'hFFF1, 16'h0081, "status_full_pushpop");
    RW = 1; DA = 16'hFF80; OUT_R = 1; #1;
    n = 0; last = 0;
    while (OUT_V && n < 20) begin
      last = OUT_D;
      @(posedge CK); #1;
      n++;
    end
    check("drain_count", 16'(n), 16'd8);
    check("drain_last", last, 16'h0055);
    OUT_R = 0;

    // held identical store pushes once
    repeat (5) step(0, 16'hFFF0, 16'h0007, 0);
    rd(16'hFFF1, 16'h0010, "held_store_once");
    step(1, 16'hFF80, 0, 1);

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      int sel;
      RST  = ($urandom_range(0, 199) == 0);
      IN_D = 16'($urandom);
      OUT_R = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        RW  = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 9);
        if (sel < 4)      DA = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 7))};
        else if (sel < 7) DA = 16'hFFF0;
        else if (sel < 8) DA = 16'hFFF1;
        else              DA = {12'hFFF, 4'($urandom_range(2, 15))};
        tb_dd = 16'($urandom_range(0, 3));
      end
      @(posedge CK); #1;
    end
    RST = 0;
    repeat (4) step(1, 16'hFFF1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
